rv_pbus_arb: RTL

Peripheral-bus access scheduler for the rv32 core's shared instruction/data RAM. It accepts single-word read and write requests from a host-side master (debug/loader or bus bridge) over a valid/ready handshake. It drives the RAM's peripheral port (p_*), which loses to the core data bus whenever both contend. If a request waits too long, the block asserts a hold to the core so that the request is guaranteed to complete.

---
 rtl/rv_pbus_arb_if.sv | 26 ++
 rtl/rv_pbus_arb.sv | 71 +++++++
 2 files changed

// File: rtl/rv_pbus_arb_if.sv
// rv_pbus_arb_if: host request channel, RAM peripheral port and core hold line.
interface rv_pbus_arb_if;
  logic        rdy;
  logic        h_valid;
  logic        h_ready;
  logic        h_we;
  logic [31:0] h_adr;
  logic [31:0] h_dw;
  logic        h_done;
  logic [31:0] h_rdata;
  logic [31:0] p_adr;
  logic [31:0] p_dw;
  logic        p_we;
  logic        p_re;
  logic        p_ack;
  logic [31:0] p_dr;
  logic        d_hold;
  modport slave (
    input  rdy, h_valid, h_we, h_adr, h_dw, p_ack, p_dr,
    output h_ready, h_done, h_rdata, p_adr, p_dw, p_we, p_re, d_hold
  );
  modport master (
    output rdy, h_valid, h_we, h_adr, h_dw, p_ack, p_dr,
    input  h_ready, h_done, h_rdata, p_adr, p_dw, p_we, p_re, d_hold
  );
endinterface

// File: rtl/rv_pbus_arb.sv
// rv_pbus_arb: single-outstanding host access to the shared RAM peripheral port,
// raising d_hold towards the core when a request is starved for too long.
module rv_pbus_arb #(
  parameter int STARVE_MAX = 16,
  parameter int CNT_W      = 8
) (
  input logic          clk,
  input logic          reset,
  rv_pbus_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, RDATA} state_t;
  state_t           r_state, w_next;
  logic             r_we;
  logic [31:0]      r_adr;
  logic [31:0]      r_dw;
  logic [31:0]      r_rdata;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_hold;
  logic             w_accept;
  logic             w_grant;
  logic             w_starve;
  logic [CNT_W:0]   w_cnt_inc;
  assign w_accept  = r_state == IDLE && bus.h_valid;
  // the RAM read path is not rdy-gated, only writes wait for rdy
  assign w_grant   = r_state == REQ && bus.p_ack && (!r_we || bus.rdy);
  assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
  assign w_starve  = r_state == REQ && !w_grant && w_cnt_inc >= (CNT_W+1)'(STARVE_MAX);
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.h_valid ? REQ : IDLE;
      REQ:     w_next = w_grant ? (r_we ? IDLE : RDATA) : REQ;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    bus.h_ready = r_state == IDLE;
    bus.p_we    = r_state == REQ && r_we;
    bus.p_re    = r_state == REQ && !r_we;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dw    <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_hold  <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we  <= bus.h_we;
        r_adr <= bus.h_adr & ~32'd3;
        r_dw  <= bus.h_dw;
      end
      r_cnt  <= (w_accept || w_grant) ? '0 :
                (r_state == REQ && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
      r_done <= (w_grant && r_we) || r_state == RDATA;
      r_hold <= w_starve;
      if (r_state == RDATA) r_rdata <= bus.p_dr;
    end
  assign bus.p_adr   = r_adr;
  assign bus.p_dw    = r_dw;
  assign bus.h_done  = r_done;
  assign bus.h_rdata = r_rdata;
  assign bus.d_hold  = r_hold;
endmodule
